// File: rtl/rx_packetizer_if.sv
// ---------------------------------------------------------------------------
// rx_packetizer_if
//   Signal bundle for the rx_packetizer. It carries the sample bus coming
//   from the DSP chain and the write port going to the USB receive FIFO.
//
//   in_strobe        one-cycle qualifier for in_i / in_q
//   in_i, in_q       16-bit I and Q samples
//   rxstrobe         output word valid, one word per high cycle
//   rxdata           16-bit output word
//
//   master : DSP / FIFO side (drives samples, observes output words)
//   slave  : packetizer side (consumes samples, drives output words)
// ---------------------------------------------------------------------------
interface rx_packetizer_if;
  logic        in_strobe;
  logic [15:0] in_i;
  logic [15:0] in_q;
  logic        rxstrobe;
  logic [15:0] rxdata;

  modport master (
    output in_strobe, in_i, in_q,
    input  rxstrobe, rxdata
  );

  modport slave (
    input  in_strobe, in_i, in_q,
    output rxstrobe, rxdata
  );
endinterface

// File: rtl/rx_packetizer.sv
// ---------------------------------------------------------------------------
// rx_packetizer
//   Serializes I/Q sample pairs into fixed-length 16-bit packets for the USB
//   receive FIFO: header {TAG, seq}, interleaved I/Q words, then an XOR
//   checksum over the data words. Packet length matches the host read burst
//   so each host read sees whole frames.
//
//   Parameters
//     PKT_LEN       total words per packet (header + data + checksum), even,
//                   4..256
//     TAG           constant in header bits [15:12]
//
//   Ports
//     rxclk         sole clock, posedge
//     rst           synchronous, active-low reset
//     enable        permits sample capture and packet start
//     clear_status  clears rx_overrun and drop_count
//     bus           sample input / FIFO write port (slave modport)
//     in_packet     high from header word through checksum word
//     rx_overrun    sticky: a sample pair was dropped
//     drop_count    dropped pairs, saturating at 255
// ---------------------------------------------------------------------------
module rx_packetizer #(
  parameter int unsigned PKT_LEN = 256,
  parameter logic [3:0]  TAG     = 4'hA
) (
  input  logic           rxclk,
  input  logic           rst,
  input  logic           enable,
  input  logic           clear_status,
  rx_packetizer_if.slave bus,
  output logic           in_packet,
  output logic           rx_overrun,
  output logic [7:0]     drop_count
);

  localparam int unsigned NPAIR   = (PKT_LEN - 2) / 2;
  localparam logic [6:0]  NPAIR_L = 7'(NPAIR);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HDR    = 3'd1;
  localparam logic [2:0] S_EMIT_I = 3'd2;
  localparam logic [2:0] S_EMIT_Q = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_CSUM   = 3'd5;

  // -------------------------------------------------------------------------
  // Two-entry pair FIFO. Fullness is judged on the registered count, so a
  // pop on the same edge never makes room for an incoming pair.
  // -------------------------------------------------------------------------
  logic [31:0] fifo_mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  fifo_cnt;
  logic        fifo_full;
  logic        fifo_empty;
  logic        wr_en;
  logic        rd_en;
  logic        drop;
  logic [31:0] fifo_head;

  logic [2:0]  state;
  logic [2:0]  state_nxt;

  assign fifo_full  = (fifo_cnt == 2'd2);
  assign fifo_empty = (fifo_cnt == 2'd0);
  assign wr_en      = bus.in_strobe & enable & ~fifo_full;
  assign drop       = bus.in_strobe & enable & fifo_full;
  // EMIT_I is only ever entered with the FIFO non-empty.
  assign rd_en      = (state == S_EMIT_I);
  assign fifo_head  = fifo_mem[rd_ptr];

  // NOTE: storage arrays carry no reset; validity is tracked by the pointers
  // and count, so resetting the data would only add reset fan-out.
  always_ff @(posedge rxclk) begin
    if (wr_en) begin
      fifo_mem[wr_ptr] <= {bus.in_i, bus.in_q};
    end
  end

  // NOTE: every register is assigned with <= so all state updates on an edge
  // see the pre-edge values, regardless of statement order.
  always_ff @(posedge rxclk) begin
    if (!rst) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (wr_en) wr_ptr <= ~wr_ptr;
      if (rd_en) rd_ptr <= ~rd_ptr;
      case ({wr_en, rd_en})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Serializer control
  // -------------------------------------------------------------------------
  logic [6:0]  pair_cnt;
  logic [11:0] seq;
  logic [15:0] csum;
  logic [15:0] q_hold;
  logic        rxstrobe_r;
  logic [15:0] rxdata_r;

  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (!fifo_empty && enable) state_nxt = S_HDR;
      S_HDR:    state_nxt = S_EMIT_I;
      S_EMIT_I: state_nxt = S_EMIT_Q;
      S_EMIT_Q: begin
        if (pair_cnt == NPAIR_L - 7'd1) state_nxt = S_CSUM;
        else if (!fifo_empty)           state_nxt = S_EMIT_I;
        else                            state_nxt = S_WAIT;
      end
      // A started packet never aborts; it waits for enabled samples.
      S_WAIT:   if (!fifo_empty) state_nxt = S_EMIT_I;
      S_CSUM:   state_nxt = (!fifo_empty && enable) ? S_HDR : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge rxclk) begin
    if (!rst) begin
      state      <= S_IDLE;
      pair_cnt   <= 7'd0;
      seq        <= 12'd0;
      csum       <= 16'd0;
      q_hold     <= 16'd0;
      rxstrobe_r <= 1'b0;
      rxdata_r   <= 16'd0;
      in_packet  <= 1'b0;
    end else begin
      state      <= state_nxt;
      rxstrobe_r <= 1'b0;
      // Being in any non-idle state means the word leaving this edge belongs
      // to a packet; this also keeps in_packet high across back-to-back
      // packets and drops it one cycle after the checksum otherwise.
      in_packet  <= (state != S_IDLE);
      case (state)
        S_HDR: begin
          rxstrobe_r <= 1'b1;
          rxdata_r   <= {TAG, seq};
          csum       <= 16'd0;
          pair_cnt   <= 7'd0;
        end
        S_EMIT_I: begin
          rxstrobe_r <= 1'b1;
          rxdata_r   <= fifo_head[31:16];
          csum       <= csum ^ fifo_head[31:16];
          // The pair is popped here, so Q is kept for the next cycle.
          q_hold     <= fifo_head[15:0];
        end
        S_EMIT_Q: begin
          rxstrobe_r <= 1'b1;
          rxdata_r   <= q_hold;
          csum       <= csum ^ q_hold;
          pair_cnt   <= pair_cnt + 7'd1;
        end
        S_CSUM: begin
          rxstrobe_r <= 1'b1;
          rxdata_r   <= csum;
          seq        <= seq + 12'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.rxstrobe = rxstrobe_r;
  assign bus.rxdata   = rxdata_r;

  // -------------------------------------------------------------------------
  // Status: a drop coinciding with clear_status leaves a count of one.
  // -------------------------------------------------------------------------
  always_ff @(posedge rxclk) begin
    if (!rst) begin
      rx_overrun <= 1'b0;
      drop_count <= 8'd0;
    end else if (drop) begin
      rx_overrun <= 1'b1;
      if (clear_status)             drop_count <= 8'd1;
      else if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end else if (clear_status) begin
      rx_overrun <= 1'b0;
      drop_count <= 8'd0;
    end
  end

endmodule
